// File: rtl/rgb2ycbcr_ctrl.sv
// rgb2ycbcr_ctrl: packs a serial RGB pixel stream into 8-pixel groups,
// issues each group to the 8-lane converter under downstream credit control,
// and delays frame-position tags so they line up with the converter output.
//
// Pixel handshake: a pixel transfers on a rising edge where i_pix_valid and
// o_pix_ready are both 1. o_pix_ready depends only on registered state, and
// the source may hold or drop i_pix_valid freely while o_pix_ready is 0.
module rgb2ycbcr_ctrl #(
    parameter int IMG_WIDTH    = 224,
    parameter int IMG_HEIGHT   = 224,
    parameter int CONV_LATENCY = 3,
    parameter int OUT_CREDITS  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [23:0]  i_pix_data,
    input  logic         i_pix_valid,
    output logic         o_pix_ready,
    output logic [191:0] o_conv_data,
    output logic         o_conv_valid,
    input  logic         i_credit_ret,
    output logic         o_tag_valid,
    output logic         o_tag_sof,
    output logic         o_tag_eol,
    output logic         o_tag_eof,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_credit_err,
    output logic [1:0]   o_dbg_state
);

    localparam int GRPS = IMG_WIDTH / 8;
    localparam int GW   = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW   = $clog2(OUT_CREDITS + 1);

    localparam logic [GW-1:0] GRP_LAST = GW'(GRPS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(OUT_CREDITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    lane_q, lane_d;
    logic [GW-1:0] grp_q, grp_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          err_q, err_d;
    logic [7:0][23:0] buf_q;
    // Each tag stage holds {valid, sof, eol, eof}.
    logic [3:0]    tag_q [CONV_LATENCY];

    logic accept;
    logic issue;
    logic tag_sof;
    logic tag_eol;
    logic tag_eof;

    // Transfer strobes and the position tags of the group currently held.
    always_comb begin
        accept  = (state_q == S_FILL) && i_pix_valid;
        issue   = (state_q == S_ISSUE) && (cred_q != '0);
        tag_sof = (grp_q == '0) && (row_q == '0);
        tag_eol = (grp_q == GRP_LAST);
        tag_eof = tag_eol && (row_q == ROW_LAST);
    end

    // Next-state decode for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_FILL;
            S_FILL:  if (accept && (lane_q == 3'd7)) state_d = S_ISSUE;
            S_ISSUE: if (issue) state_d = tag_eof ? S_DONE : S_FILL;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane, group and row counters; group/row advance once per issued group.
    always_comb begin
        lane_d = lane_q;
        grp_d  = grp_q;
        row_d  = row_q;
        if ((state_q == S_IDLE) && i_start) begin
            lane_d = '0;
            grp_d  = '0;
            row_d  = '0;
        end
        if (accept) begin
            lane_d = lane_q + 3'd1;
        end
        if (issue) begin
            if (tag_eol) begin
                grp_d = '0;
                row_d = tag_eof ? '0 : row_q + RW'(1);
            end else begin
                grp_d = grp_q + GW'(1);
            end
        end
    end

    // Credit counter: issue consumes, return refills; a return into a full
    // counter saturates and latches the error flag.
    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (issue && !i_credit_ret) begin
            cred_d = cred_q - CW'(1);
        end else if (!issue && i_credit_ret) begin
            if (cred_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + CW'(1);
            end
        end
    end

    // State, counters and credit registers; reset also restores all credits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            grp_q   <= '0;
            row_q   <= '0;
            cred_q  <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            grp_q   <= grp_d;
            row_q   <= row_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    // Group buffer: written only while filling, so it is stable during issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_q <= '0;
        end else if (accept) begin
            buf_q[lane_q] <= i_pix_data;
        end
    end

    // Tag delay line matched to the converter latency; reset flushes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < CONV_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= issue ? {1'b1, tag_sof, tag_eol, tag_eof} : 4'b0000;
            for (int i = 1; i < CONV_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign o_pix_ready  = (state_q == S_FILL);
    assign o_conv_valid = issue;
    assign o_conv_data  = buf_q;
    assign o_tag_valid  = tag_q[CONV_LATENCY-1][3];
    assign o_tag_sof    = tag_q[CONV_LATENCY-1][2];
    assign o_tag_eol    = tag_q[CONV_LATENCY-1][1];
    assign o_tag_eof    = tag_q[CONV_LATENCY-1][0];
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_credit_err = err_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_rgb2ycbcr_ctrl.sv
// Testbench for rgb2ycbcr_ctrl: small frame (16x2), latency 3, two credits.
module tb_rgb2ycbcr_ctrl;

    localparam int W    = 16;
    localparam int H    = 2;
    localparam int LAT  = 3;
    localparam int CRED = 2;
    localparam int GPL  = W / 8;
    localparam int GPF  = GPL * H;

    // clock / reset and DUT signals
    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [23:0]  i_pix_data;
    logic         i_pix_valid;
    logic         o_pix_ready;
    logic [191:0] o_conv_data;
    logic         o_conv_valid;
    logic         i_credit_ret;
    logic         o_tag_valid;
    logic         o_tag_sof;
    logic         o_tag_eol;
    logic         o_tag_eof;
    logic         o_busy;
    logic         o_done;
    logic         o_credit_err;
    logic [1:0]   o_dbg_state;

    logic man_ret;
    logic auto_ret_q;
    assign i_credit_ret = man_ret | auto_ret_q;

    always #5 i_clk = ~i_clk;

    rgb2ycbcr_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONV_LATENCY(LAT), .OUT_CREDITS(CRED)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_pix_data(i_pix_data), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
        .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid), .i_credit_ret(i_credit_ret),
        .o_tag_valid(o_tag_valid), .o_tag_sof(o_tag_sof), .o_tag_eol(o_tag_eol),
        .o_tag_eof(o_tag_eof), .o_busy(o_busy), .o_done(o_done),
        .o_credit_err(o_credit_err), .o_dbg_state(o_dbg_state)
    );

    // scoreboard state
    int           vectors;
    int           miscompares;
    logic [191:0] exp_q[$];
    logic [2:0]   exp_tag_q[$];
    int           iss_cyc_q[$];
    int           issue_log[$];
    logic [23:0]  acc_q[$];
    int           mdl_g;
    int           cyc;
    int           done_cnt;
    logic         ret_en;
    logic         ret_pend;
    logic [23:0]  next_pix;

    // model: collect accepted pixels, emit expected group and tags every 8
    task automatic model_push(input logic [23:0] p);
        logic [191:0] g;
        acc_q.push_back(p);
        if (acc_q.size() == 8) begin
            g = '0;
            for (int k = 0; k < 8; k++) g[24*k +: 24] = acc_q[k];
            exp_q.push_back(g);
            exp_tag_q.push_back({(mdl_g == 0), ((mdl_g % GPL) == GPL - 1), (mdl_g == GPF - 1)});
            acc_q.delete();
            mdl_g++;
        end
    endtask

    // output monitor: pops the scoreboard on every issue and every tag
    task automatic monitor();
        logic [191:0] ed;
        logic [2:0]   et;
        int           ic;
        forever begin
            @(negedge i_clk);
            cyc++;
            auto_ret_q = ret_pend;
            ret_pend   = ret_en & o_conv_valid;
            if (o_done) done_cnt++;
            if (o_conv_valid) begin
                issue_log.push_back(cyc);
                iss_cyc_q.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL conv_data: unexpected issue at cycle %0d data=%h, want no issue", cyc, o_conv_data);
                end else begin
                    ed = exp_q.pop_front();
                    if (o_conv_data !== ed) begin
                        miscompares++;
                        $display("FAIL conv_data: got %h want %h", o_conv_data, ed);
                    end
                end
            end
            vectors++;
            if (o_tag_valid) begin
                if (exp_tag_q.size() == 0 || iss_cyc_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tag: unexpected tag at cycle %0d sof/eol/eof=%b", cyc,
                             {o_tag_sof, o_tag_eol, o_tag_eof});
                end else begin
                    et = exp_tag_q.pop_front();
                    ic = iss_cyc_q.pop_front();
                    if ({o_tag_sof, o_tag_eol, o_tag_eof} !== et || cyc != ic + LAT) begin
                        miscompares++;
                        $display("FAIL tag: got %b at cycle %0d, want %b at cycle %0d",
                                 {o_tag_sof, o_tag_eol, o_tag_eof}, cyc, et, ic + LAT);
                    end
                end
            end else if ({o_tag_sof, o_tag_eol, o_tag_eof} !== 3'b000) begin
                miscompares++;
                $display("FAIL tag_idle: got %b with tag_valid=0, want 000",
                         {o_tag_sof, o_tag_eol, o_tag_eof});
            end
        end
    endtask

    // driver: start pulse, checks the FILL entry one cycle later
    task automatic start_frame();
        acc_q.delete();
        mdl_g    = 0;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        vectors++;
        if ({o_busy, o_pix_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL start_fill: busy/ready=%b want 11", {o_busy, o_pix_ready});
        end
    endtask

    // driver: offer pixels; pattern 0 = always valid, 1 = valid every other cycle
    task automatic send_pix(input int n, input int pattern, input int start_at);
        int   sent;
        int   k;
        logic v;
        sent = 0;
        k    = 0;
        while (sent < n && k < 400) begin
            v           = (pattern == 0) ? 1'b1 : ((k % 2) == 0);
            i_pix_valid = v;
            i_pix_data  = next_pix;
            i_start     = (k == start_at);
            if (v && o_pix_ready) begin
                model_push(next_pix);
                next_pix = next_pix + 24'd1;
                sent++;
            end
            @(negedge i_clk);
            k++;
        end
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        vectors++;
        if (sent < n) begin
            miscompares++;
            $display("FAIL send_timeout: accepted %0d pixels want %0d", sent, n);
        end
    endtask

    // driver: wait for the frame to finish and all tags to drain
    task automatic wait_idle();
        int n;
        n = 0;
        while ((o_busy || exp_tag_q.size() != 0) && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        vectors++;
        if (o_busy || exp_tag_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: busy=%0b tags_left=%0d want 0 and 0", o_busy, exp_tag_q.size());
        end
    endtask

    task automatic pulse_ret(input int n);
        man_ret = 1'b1;
        repeat (n) @(negedge i_clk);
        man_ret = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        vectors++;
        if ({o_pix_ready, o_conv_valid, o_tag_valid, o_tag_sof, o_tag_eol, o_tag_eof,
             o_busy, o_done, o_credit_err} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000000",
                     {o_pix_ready, o_conv_valid, o_tag_valid, o_tag_sof, o_tag_eol, o_tag_eof,
                      o_busy, o_done, o_credit_err});
        end
        vectors++;
        if (o_conv_data !== 192'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", o_conv_data);
        end
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        vectors++;
        if ({o_busy, o_pix_ready, o_conv_valid, o_done, o_dbg_state} !== 6'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b want 000000",
                     {o_busy, o_pix_ready, o_conv_valid, o_done, o_dbg_state});
        end
    endtask

    task automatic test_full_frame();
        ret_en   = 1'b1;
        next_pix = 24'h000001;
        issue_log.delete();
        done_cnt = 0;
        start_frame();
        send_pix(32, 0, -1);
        wait_idle();
        repeat (2) @(negedge i_clk);
        vectors++;
        if (issue_log.size() != 4) begin
            miscompares++;
            $display("FAIL frame_issues: got %0d want 4", issue_log.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (issue_log[i] - issue_log[i-1] != 9) begin
                    miscompares++;
                    $display("FAIL issue_spacing: got %0d want 9", issue_log[i] - issue_log[i-1]);
                end
            end
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL done_pulses: got %0d want 1", done_cnt);
        end
        vectors++;
        if (exp_q.size() != 0 || next_pix != 24'h000021) begin
            miscompares++;
            $display("FAIL frame_consumed: groups_left=%0d next_pix=%h want 0 and 000021",
                     exp_q.size(), next_pix);
        end
        ret_en = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_valid_toggle();
        ret_en = 1'b1;
        done_cnt = 0;
        start_frame();
        send_pix(32, 1, -1);
        wait_idle();
        repeat (2) @(negedge i_clk);
        vectors++;
        if (done_cnt != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL toggle_frame: done=%0d groups_left=%0d want 1 and 0", done_cnt, exp_q.size());
        end
        ret_en = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_no_credit();
        logic [191:0] hold;
        start_frame();
        send_pix(24, 0, -1);
        hold = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (o_conv_valid !== 1'b0 || o_pix_ready !== 1'b0 || o_conv_data !== hold) begin
                miscompares++;
                $display("FAIL stall: valid=%b ready=%b data=%h want 0 0 %h",
                         o_conv_valid, o_pix_ready, o_conv_data, hold);
            end
            @(negedge i_clk);
        end
        pulse_ret(1);
        vectors++;
        if (o_conv_valid !== 1'b1 || o_conv_data !== hold) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b data=%h want 1 %h", o_conv_valid, o_conv_data, hold);
        end
        @(negedge i_clk);
        send_pix(8, 0, -1);
        repeat (2) @(negedge i_clk);
        pulse_ret(1);
        wait_idle();
        pulse_ret(2);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_credit_sat();
        vectors++;
        if (o_credit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL credit_err_pre: got %b want 0", o_credit_err);
        end
        pulse_ret(1);
        vectors++;
        if (o_credit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_err_set: got %b want 1", o_credit_err);
        end
        issue_log.delete();
        start_frame();
        send_pix(8, 0, -1);
        vectors++;
        if (o_conv_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_latency: valid=%b want 1", o_conv_valid);
        end
        // return a credit in the same cycle as the issue
        pulse_ret(1);
        send_pix(8, 0, 3);
        vectors++;
        if ({o_busy, o_dbg_state} !== 3'b110) begin
            miscompares++;
            $display("FAIL start_ignored: busy/state=%b want 110", {o_busy, o_dbg_state});
        end
        @(negedge i_clk);
        send_pix(8, 0, -1);
        repeat (2) @(negedge i_clk);
        vectors++;
        if (issue_log.size() != 3) begin
            miscompares++;
            $display("FAIL simultaneous_credit: issues=%0d want 3", issue_log.size());
        end
        send_pix(8, 0, -1);
        repeat (2) @(negedge i_clk);
        pulse_ret(1);
        wait_idle();
        pulse_ret(2);
        repeat (2) @(negedge i_clk);
        vectors++;
        if (o_credit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_err_sticky: got %b want 1", o_credit_err);
        end
    endtask

    task automatic test_reset_midframe();
        int seen;
        int n;
        start_frame();
        send_pix(9, 0, -1);
        i_rst = 1'b1;
        exp_q.delete();
        exp_tag_q.delete();
        iss_cyc_q.delete();
        acc_q.delete();
        mdl_g = 0;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_tag_valid) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_tags: got %0d tags want 0", seen);
        end
        vectors++;
        if ({o_busy, o_pix_ready, o_credit_err, o_conv_data != 192'd0} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort_state: busy/ready/err/data_nz=%b want 0000",
                     {o_busy, o_pix_ready, o_credit_err, o_conv_data != 192'd0});
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        issue_log.delete();
        start_frame();
        send_pix(16, 0, -1);
        repeat (2) @(negedge i_clk);
        vectors++;
        if (issue_log.size() != 2) begin
            miscompares++;
            $display("FAIL credit_restore: issues=%0d want 2", issue_log.size());
        end
        n = 0;
        while (exp_tag_q.size() != 0 && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        vectors++;
        if (exp_tag_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL restart_drain: tags_left=%0d groups_left=%0d want 0 0",
                     exp_tag_q.size(), exp_q.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        done_cnt    = 0;
        mdl_g       = 0;
        ret_en      = 1'b0;
        ret_pend    = 1'b0;
        auto_ret_q  = 1'b0;
        man_ret     = 1'b0;
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        next_pix    = 24'h000001;
        fork
            monitor();
        join_none
        test_reset();
        test_full_frame();
        test_valid_toggle();
        test_no_credit();
        test_credit_sat();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
